// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: renderer address/colour
// handshake, sync/colour to the pins, and frame bookkeeping strobes.
interface vga_timing_gen_if #(
  parameter int COLOUR_WIDTH    = 12,
  parameter int ADDR_WIDTH      = 10,
  parameter int FRAME_CNT_WIDTH = 16
);
  logic [COLOUR_WIDTH-1:0]    COLOUR_IN;
  logic                       PIX_TICK;
  logic [ADDR_WIDTH-1:0]      ADDRH;
  logic [ADDR_WIDTH-1:0]      ADDRV;
  logic                       DISPLAY_ACTIVE;
  logic                       LINE_START;
  logic                       FRAME_START;
  logic [FRAME_CNT_WIDTH-1:0] FRAME_COUNT;
  logic [COLOUR_WIDTH-1:0]    COLOUR_OUT;
  logic                       HS;
  logic                       VS;

  modport master (
    input  COLOUR_IN,
    output PIX_TICK, ADDRH, ADDRV, DISPLAY_ACTIVE, LINE_START, FRAME_START,
           FRAME_COUNT, COLOUR_OUT, HS, VS
  );

  modport slave (
    output COLOUR_IN,
    input  PIX_TICK, ADDRH, ADDRV, DISPLAY_ACTIVE, LINE_START, FRAME_START,
           FRAME_COUNT, COLOUR_OUT, HS, VS
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel-enable divider, h/v counters,
// one-pixel registered colour/sync/active stage, line/frame strobes.
module vga_timing_gen #(
  parameter int CLK_DIV         = 4,
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_PULSE         = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_PULSE         = 2,
  parameter int V_BACK          = 33,
  parameter int HS_POL          = 0,
  parameter int VS_POL          = 0,
  parameter int COLOUR_WIDTH    = 12,
  parameter int ADDR_WIDTH      = 10,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_PULSE + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_PULSE;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_PULSE;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);

  typedef logic [ADDR_WIDTH-1:0]      addr_t;
  typedef logic [DIV_W-1:0]           div_t;
  typedef logic [FRAME_CNT_WIDTH-1:0] fcnt_t;
  typedef logic [COLOUR_WIDTH-1:0]    col_t;

  div_t  div_q, div_d;
  logic  pix_tick_q, pix_tick_d;
  addr_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  fcnt_t frame_cnt_q, frame_cnt_d;
  col_t  colour_q, colour_d;
  logic  active_q, active_d, hs_q, hs_d, vs_q, vs_d;
  logic  div_last, visible, h_last, v_last, hs_on, vs_on;

  always_comb begin
    div_last   = (div_q == div_t'(CLK_DIV - 1));
    visible    = (h_cnt_q < addr_t'(H_DISPLAY)) && (v_cnt_q < addr_t'(V_DISPLAY));
    h_last     = (h_cnt_q == addr_t'(H_TOTAL - 1));
    v_last     = (v_cnt_q == addr_t'(V_TOTAL - 1));
    hs_on      = (h_cnt_q >= addr_t'(HS_START)) && (h_cnt_q < addr_t'(HS_END));
    vs_on      = (v_cnt_q >= addr_t'(VS_START)) && (v_cnt_q < addr_t'(VS_END));

    div_d      = div_last ? '0 : div_q + div_t'(1);
    pix_tick_d = div_last;

    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    colour_d    = colour_q;
    active_d    = active_q;
    hs_d        = hs_q;
    vs_d        = vs_q;

    // Stage 1 samples the pre-advance counters, so colour, sync and the
    // active flag all describe the same pixel one period later.
    if (pix_tick_q) begin
      h_cnt_d  = h_last ? '0 : h_cnt_q + addr_t'(1);
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + addr_t'(1);
        if (v_last) frame_cnt_d = frame_cnt_q + fcnt_t'(1);
      end
      colour_d = visible ? vga.COLOUR_IN : '0;
      active_d = visible;
      hs_d     = hs_on ? HS_ACT : ~HS_ACT;
      vs_d     = vs_on ? VS_ACT : ~VS_ACT;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q       <= '0;
      pix_tick_q  <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      colour_q    <= '0;
      active_q    <= 1'b0;
      hs_q        <= ~HS_ACT;
      vs_q        <= ~VS_ACT;
    end else begin
      div_q       <= div_d;
      pix_tick_q  <= pix_tick_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      colour_q    <= colour_d;
      active_q    <= active_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign vga.PIX_TICK       = pix_tick_q;
  assign vga.ADDRH          = visible ? h_cnt_q : '0;
  assign vga.ADDRV          = visible ? v_cnt_q : '0;
  assign vga.LINE_START     = pix_tick_q && (h_cnt_q == '0);
  assign vga.FRAME_START    = pix_tick_q && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign vga.FRAME_COUNT    = frame_cnt_q;
  assign vga.COLOUR_OUT     = colour_q;
  assign vga.DISPLAY_ACTIVE = active_q;
  assign vga.HS             = hs_q;
  assign vga.VS             = vs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance for divider/line/colour
// timing, and a tiny CLK_DIV=1 instance for frame, polarity and mid-frame reset.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOUR_WIDTH(12), .ADDR_WIDTH(10), .FRAME_CNT_WIDTH(16)) vga_a ();
  vga_timing_gen_if #(.COLOUR_WIDTH(12), .ADDR_WIDTH(4),  .FRAME_CNT_WIDTH(2))  vga_b ();

  vga_timing_gen dut_a (.CLK(clk), .RESET(rst_a), .vga(vga_a));

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_PULSE(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_PULSE(1), .V_BACK(1),
    .HS_POL(1), .VS_POL(1), .COLOUR_WIDTH(12), .ADDR_WIDTH(4), .FRAME_CNT_WIDTH(2)
  ) dut_b (.CLK(clk), .RESET(rst_b), .vga(vga_b));

  // Renderer stand-in for the small instance: colour encodes its own address.
  assign vga_b.COLOUR_IN = 12'h100 | 12'({vga_b.ADDRV, vga_b.ADDRH});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Default-instance line statistics over ticks k = 0..1605.
  int hs_lo_n = 0, hs_lo_first = -1, hs_lo_last = -1;
  int col_n = 0, col_first = -1, col_last = -1;
  int da_n = 0, vs_lo_n = 0, ls_n = 0, fs_n = 0, ls2_cyc = -1;

  task automatic obs_a(input int k, input int cyc);
    if (k < 800) begin
      if (!vga_a.HS) begin
        hs_lo_n++;
        if (hs_lo_first < 0) hs_lo_first = k;
        hs_lo_last = k;
      end
      if (vga_a.COLOUR_OUT == 12'hFFF) begin
        col_n++;
        if (col_first < 0) col_first = k;
        col_last = k;
      end
      if (vga_a.DISPLAY_ACTIVE) da_n++;
    end
    if (!vga_a.VS) vs_lo_n++;
    if (vga_a.LINE_START) begin
      ls_n++;
      if (k == 800) ls2_cyc = cyc;
    end
    if (vga_a.FRAME_START) fs_n++;
    if (k == 639) chk("a_addrh_639", 32'(vga_a.ADDRH), 32'd639);
    if (k == 640) chk("a_addrh_640", 32'(vga_a.ADDRH), 32'd0);
    if (k == 640) chk("a_col_k640", 32'(vga_a.COLOUR_OUT), 32'hFFF);
    if (k == 641) chk("a_col_k641", 32'(vga_a.COLOUR_OUT), 32'h0);
    if (k == 805) chk("a_addrv_l1", 32'(vga_a.ADDRV), 32'd1);
    if (k == 805) chk("a_addrh_l1", 32'(vga_a.ADDRH), 32'd5);
  endtask

  // Small instance: tick k is h=k%8, v=(k/8)%6; stage-1 outputs reflect tick k-1.
  task automatic run_b(input string tag);
    for (int k = 0; k < 200; k++) begin
      int h, v, hp, vp;
      logic vis, vis_p;
      @(negedge clk);
      h = k % 8; v = (k / 8) % 6;
      hp = (k + 7) % 8; vp = ((k + 47) / 8) % 6;
      vis   = (h < 4) && (v < 3);
      vis_p = (k > 0) && (hp < 4) && (vp < 3);
      chk($sformatf("%s_tick@%0d", tag, k), 32'(vga_b.PIX_TICK), 32'd1);
      chk($sformatf("%s_ls@%0d", tag, k), 32'(vga_b.LINE_START), 32'(h == 0));
      chk($sformatf("%s_fs@%0d", tag, k), 32'(vga_b.FRAME_START), 32'(h == 0 && v == 0));
      chk($sformatf("%s_addrh@%0d", tag, k), 32'(vga_b.ADDRH), vis ? 32'(h) : 32'd0);
      chk($sformatf("%s_addrv@%0d", tag, k), 32'(vga_b.ADDRV), vis ? 32'(v) : 32'd0);
      chk($sformatf("%s_da@%0d", tag, k), 32'(vga_b.DISPLAY_ACTIVE), 32'(vis_p));
      chk($sformatf("%s_col@%0d", tag, k), 32'(vga_b.COLOUR_OUT),
          vis_p ? (32'h100 | 32'(vp * 16 + hp)) : 32'd0);
      chk($sformatf("%s_hs@%0d", tag, k), 32'(vga_b.HS), 32'(k > 0 && (hp == 5 || hp == 6)));
      chk($sformatf("%s_vs@%0d", tag, k), 32'(vga_b.VS), 32'(k > 0 && vp == 4));
      chk($sformatf("%s_fc@%0d", tag, k), 32'(vga_b.FRAME_COUNT), 32'((k / 48) % 4));
    end
  endtask

  initial begin
    int c, k, cyc, gap;
    vga_a.COLOUR_IN = 12'hFFF;
    repeat (3) @(negedge clk);

    chk("a_rst_tick",  32'(vga_a.PIX_TICK), 32'd0);
    chk("a_rst_hs",    32'(vga_a.HS), 32'd1);
    chk("a_rst_vs",    32'(vga_a.VS), 32'd1);
    chk("a_rst_da",    32'(vga_a.DISPLAY_ACTIVE), 32'd0);
    chk("a_rst_col",   32'(vga_a.COLOUR_OUT), 32'd0);
    chk("a_rst_fc",    32'(vga_a.FRAME_COUNT), 32'd0);
    chk("a_rst_addrh", 32'(vga_a.ADDRH), 32'd0);
    chk("a_rst_addrv", 32'(vga_a.ADDRV), 32'd0);
    chk("a_rst_ls",    32'(vga_a.LINE_START), 32'd0);
    chk("a_rst_fs",    32'(vga_a.FRAME_START), 32'd0);

    rst_a = 1'b0;
    c = 0;
    while (!vga_a.PIX_TICK && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("a_first_tick_clk", c, 32'd4);
    chk("a_first_fs", 32'(vga_a.FRAME_START), 32'd1);
    chk("a_first_ls", 32'(vga_a.LINE_START), 32'd1);

    k = 0; cyc = 0; gap = 0;
    obs_a(k, cyc);
    while (k < 1605 && cyc < 8000) begin
      @(negedge clk);
      cyc++; gap++;
      if (vga_a.PIX_TICK) begin
        k++;
        if (k == 1) chk("a_tick_period", gap, 32'd4);
        gap = 0;
        obs_a(k, cyc);
      end
    end
    chk("a_ticks_seen", k, 32'd1605);
    chk("a_hs_lo_n",     hs_lo_n, 32'd96);
    chk("a_hs_lo_first", hs_lo_first, 32'd657);
    chk("a_hs_lo_last",  hs_lo_last, 32'd752);
    chk("a_col_n",       col_n, 32'd640);
    chk("a_col_first",   col_first, 32'd1);
    chk("a_col_last",    col_last, 32'd640);
    chk("a_da_n",        da_n, 32'd640);
    chk("a_vs_lo_n",     vs_lo_n, 32'd0);
    chk("a_ls_n",        ls_n, 32'd3);
    chk("a_fs_n",        fs_n, 32'd1);
    chk("a_ls_spacing",  ls2_cyc, 32'd3200);

    // Small config, active-high syncs: reset levels are 0.
    chk("b_rst_hs", 32'(vga_b.HS), 32'd0);
    chk("b_rst_vs", 32'(vga_b.VS), 32'd0);
    rst_b = 1'b0;
    run_b("b1");

    // Advance to k=278: frame 5 (count 1), h=6, v=4, both syncs asserted.
    repeat (79) @(negedge clk);
    chk("b_pre_hs", 32'(vga_b.HS), 32'd1);
    chk("b_pre_vs", 32'(vga_b.VS), 32'd1);
    chk("b_pre_fc", 32'(vga_b.FRAME_COUNT), 32'd1);

    rst_b = 1'b1;
    #1;
    chk("b_mrst_tick",  32'(vga_b.PIX_TICK), 32'd0);
    chk("b_mrst_hs",    32'(vga_b.HS), 32'd0);
    chk("b_mrst_vs",    32'(vga_b.VS), 32'd0);
    chk("b_mrst_fc",    32'(vga_b.FRAME_COUNT), 32'd0);
    chk("b_mrst_col",   32'(vga_b.COLOUR_OUT), 32'd0);
    chk("b_mrst_da",    32'(vga_b.DISPLAY_ACTIVE), 32'd0);
    chk("b_mrst_addrh", 32'(vga_b.ADDRH), 32'd0);
    chk("b_mrst_addrv", 32'(vga_b.ADDRV), 32'd0);
    chk("b_mrst_ls",    32'(vga_b.LINE_START), 32'd0);
    chk("b_mrst_fs",    32'(vga_b.FRAME_START), 32'd0);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    run_b("b2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It replaces the fixed 640x480 controller and adds:
- an internal pixel-clock-enable divider, so it runs from the 100 MHz system clock;
- configurable timings and sync polarity;
- registered, pipeline-aligned outputs;
- line/frame strobes and a frame counter.

It sits between the game renderer (which consumes ADDRH/ADDRV and returns COLOUR_IN) and the board VGA pins.

Parameters:
- CLK_DIV, 4: CLK cycles per pixel (>=1).
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_PULSE, 96: horizontal sync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_PULSE, 2: vertical sync width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- HS_POL, 0: HS active level (0 = active-low).
- VS_POL, 0: VS active level (0 = active-low).
- COLOUR_WIDTH, 12: RGB bus width.
- ADDR_WIDTH, 10: width of the pixel address outputs. Must hold H_TOTAL-1 and V_TOTAL-1.
- FRAME_CNT_WIDTH, 16: width of the frame counter.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active-high.
- COLOUR_IN  in  COLOUR_WIDTH  pixel colour for the current ADDRH/ADDRV.
- PIX_TICK  out  1  pixel enable, one CLK wide.
- ADDRH  out  ADDR_WIDTH  visible x coordinate; 0 when blanked.
- ADDRV  out  ADDR_WIDTH  visible y coordinate; 0 when blanked.
- DISPLAY_ACTIVE  out  1  registered; high while COLOUR_OUT carries visible data.
- LINE_START  out  1  one-CLK strobe at the first pixel of each line.
- FRAME_START  out  1  one-CLK strobe at pixel (0,0).
- FRAME_COUNT  out  FRAME_CNT_WIDTH  number of completed frames; wraps.
- COLOUR_OUT  out  COLOUR_WIDTH  registered colour to the pins.
- HS  out  1  registered horizontal sync.
- VS  out  1  registered vertical sync.

Behaviour:
Totals and sync windows:
- H_TOTAL = H_DISPLAY + H_FRONT + H_PULSE + H_BACK (800 at defaults).
- V_TOTAL is formed the same way (525 at defaults).
- Count order is display, front porch, sync, back porch. Visible region is h_cnt < H_DISPLAY and v_cnt < V_DISPLAY.
- HS is active for H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_PULSE. VS uses the same rule on v_cnt with the V_ parameters.

Reset (asynchronous, RESET=1):
- Divider, h_cnt, v_cnt, FRAME_COUNT, COLOUR_OUT, DISPLAY_ACTIVE, PIX_TICK, LINE_START and FRAME_START all go to 0.
- HS goes to !HS_POL and VS goes to !VS_POL (inactive).
- ADDRH and ADDRV read 0.
- Reset mid-frame restarts cleanly at pixel (0,0). No partial sync pulse is emitted after release.

Divider:
- div counts 0..CLK_DIV-1 and wraps.
- PIX_TICK is registered and high for the CLK cycle following div==CLK_DIV-1.
- First PIX_TICK occurs CLK_DIV cycles after reset release.
- With CLK_DIV=1, PIX_TICK is high every cycle after the first.

Counters (advance only on PIX_TICK):
- h_cnt wraps at H_TOTAL-1 to 0.
- v_cnt increments when h_cnt wraps, and wraps at V_TOTAL-1.
- FRAME_COUNT increments on the tick where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. It wraps from all-ones to 0.

Stage 0 (combinational from the counter registers):
- ADDRH = h_cnt and ADDRV = v_cnt inside the visible region; otherwise both are 0.
- The renderer must present COLOUR_IN for that address within the same pixel period.

Stage 1 (registered on PIX_TICK, latency exactly one pixel):
- COLOUR_OUT = visible ? COLOUR_IN : 0.
- DISPLAY_ACTIVE = visible.
- HS and VS are computed from the same h_cnt/v_cnt.
- Colour, sync and active flag are therefore always mutually aligned.
- Between ticks, all stage-1 outputs hold their value.

Strobes:
- LINE_START = PIX_TICK && h_cnt==0. It fires on every line, including blanked lines.
- FRAME_START = PIX_TICK && h_cnt==0 && v_cnt==0. It coincides with a LINE_START pulse.
- Both are combinational from registers, so they are glitch-free.
- The first FRAME_START after reset occurs on the first PIX_TICK.

Test Plan:
- Reset check: hold RESET with defaults -> all outputs 0, HS=1, VS=1. Release -> first PIX_TICK at CLK 4 after release; PIX_TICK period 4 CLKs thereafter.
- Line timing, defaults: HS low for exactly 96 consecutive pixel ticks, first low tick registered from h_cnt=656. LINE_START spacing is 800 ticks (3200 CLKs).
- Frame timing, defaults: VS low for 2 lines (1600 ticks), starting at line 490. FRAME_START spacing is 420000 ticks. FRAME_COUNT reads 1 after the first full frame.
- Colour path: drive COLOUR_IN=12'hFFF constantly. COLOUR_OUT=FFF exactly on the 640x480 visible ticks (one tick after ADDR) and 0 in blanking. ADDRH=639 at h_cnt=639 and 0 at h_cnt=640.
- Small config: CLK_DIV=1, H=4/1/2/1, V=3/1/1/1, HS_POL=VS_POL=1, FRAME_CNT_WIDTH=2 -> HS high at h_cnt 5..6, line of 8 CLKs. FRAME_COUNT goes 0,1,2,3,0 over 4 frames of 48 CLKs each.
- Mid-frame reset: assert RESET at h=300, v=200 for 3 CLKs -> outputs return to reset values immediately. Timing restarts at (0,0) with FRAME_START on the first tick; FRAME_COUNT is 0.
